uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a first-word-fall-through byte FIFO
// Optional even-parity support is compiled in with UART_RX_PARITY_EN.
module uart_rx_fifo #(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          ext_clk,
  input  logic                          ext_rst_n,
  input  logic                          uart_rxd,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          overrun_err,
  output logic                          frame_err,
  input  logic                          err_clr
`ifdef UART_RX_PARITY_EN
  ,
  output logic                          parity_err
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] FULL_CNT = 16'(BAUD_DIV);
  localparam logic [15:0] HALF_CNT = 16'(BAUD_DIV / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic          rxd_s1_q, rxd_s2_q;
  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          push, frame_set;
  logic          tick;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    data_q, data_d;
  logic          overrun_q, overrun_d, frame_q, frame_d;
  logic          pop, full, wr_en, overrun_set;

`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d, parity_set;
  logic          parity_q, parity_d;
`endif

  assign tick = (cnt_q == 16'd1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    parity_set = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rxd_s2_q) begin
          state_d = S_START;
          cnt_d   = HALF_CNT;
        end
      end
      S_START: begin
        if (!tick) begin
          cnt_d = cnt_q - 16'd1;
        end else if (rxd_s2_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = S_DATA;
          cnt_d   = FULL_CNT;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          shift_d = {rxd_s2_q, shift_q[7:1]};
          cnt_d   = FULL_CNT;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (!tick) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          // Even parity: data bits plus parity bit must XOR to zero.
          par_bad_d  = (^shift_q) ^ rxd_s2_q;
          parity_set = (^shift_q) ^ rxd_s2_q;
          cnt_d      = FULL_CNT;
          state_d    = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          cnt_d = '0;
          if (rxd_s2_q) begin
`ifdef UART_RX_PARITY_EN
            push = !par_bad_q;
`else
            push = 1'b1;
`endif
            state_d = S_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rxd_s2_q) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_valid    = (count_q != '0);
  assign full        = (count_q == CW'(FIFO_DEPTH));
  assign pop         = rx_valid && rx_ready;
  assign wr_en       = push && (!full || pop);
  assign overrun_set = push && full && !pop;
  assign rd_next     = rd_ptr_q + 1'b1;

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_next : rd_ptr_q;
    count_d  = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // The output register tracks the head so rx_data holds its value once the FIFO drains.
    data_d = data_q;
    if (wr_en && (count_q == '0 || (pop && count_q == CW'(1)))) begin
      data_d = shift_q;
    end else if (pop && count_q > CW'(1)) begin
      data_d = mem_q[rd_next];
    end
    overrun_d = overrun_set ? 1'b1 : (err_clr ? 1'b0 : overrun_q);
    frame_d   = frame_set   ? 1'b1 : (err_clr ? 1'b0 : frame_q);
`ifdef UART_RX_PARITY_EN
    parity_d  = parity_set  ? 1'b1 : (err_clr ? 1'b0 : parity_q);
`endif
  end

  always_ff @(posedge ext_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge ext_clk or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      rxd_s1_q  <= 1'b1;
      rxd_s2_q  <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      data_q    <= 8'h00;
      overrun_q <= 1'b0;
      frame_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      parity_q  <= 1'b0;
`endif
    end else begin
      rxd_s1_q  <= uart_rxd;
      rxd_s2_q  <= rxd_s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
      frame_q   <= frame_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      parity_q  <= parity_d;
`endif
    end
  end

  assign rx_data     = data_q;
  assign rx_count    = count_q;
  assign overrun_err = overrun_q;
  assign frame_err   = frame_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo (BAUD_DIV=16, FIFO_DEPTH=4)
module tb_uart_rx_fifo;

  localparam int BD = 16;
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ready_man = 1'b0;
  logic       ready_rand = 1'b0;
  logic       rand_en = 1'b0;
  logic       rx_ready_w;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] rx_count;
  logic       overrun_err;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int         checks = 0;
  int         failures = 0;
  logic [7:0] sb_q[$];
  logic [7:0] exp_b;
  logic [7:0] last_pop = 8'h00;
  logic       exp_frame;

  assign rx_ready_w = rand_en ? ready_rand : rx_ready_man;

  uart_rx_fifo #(.BAUD_DIV(BD), .FIFO_DEPTH(FD)) dut (
    .ext_clk     (clk),
    .ext_rst_n   (rst_n),
    .uart_rxd    (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready_w),
    .rx_count    (rx_count),
    .overrun_err (overrun_err),
    .frame_err   (frame_err),
    .err_clr     (err_clr)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake pops the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready_w) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop actual=%0h expected=none", rx_data);
      end else begin
        exp_b = sb_q.pop_front();
        chk("pop_data", rx_data, exp_b);
      end
      last_pop = rx_data;
    end
  end

  always @(posedge clk) ready_rand <= 1'($urandom_range(0, 1));

  task automatic pulse_clr();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
  endtask

  // Frame: start, 8 data LSB first, optional parity, stop. Line is left at the stop level.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit exp_push,
                           input bit pop_at_stop, input bit chk_lat);
    @(posedge clk); #1 rxd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (BD) @(posedge clk);
      #1 rxd = b[i];
    end
`ifdef UART_RX_PARITY_EN
    repeat (BD) @(posedge clk);
    #1 rxd = ^b;
`endif
    repeat (BD) @(posedge clk);
    #1 rxd = stop_ok;
    if (exp_push) sb_q.push_back(b);
    // Stop sample happens 10 clocks into the stop bit (2-flop sync + half-bit offset).
    repeat (10) @(posedge clk);
    #1 if (pop_at_stop) rx_ready_man = 1'b1;
    @(negedge clk);
    if (chk_lat) chk("valid_before_push", rx_valid, 1'b0);
    @(posedge clk);
    #1 if (pop_at_stop) rx_ready_man = 1'b0;
    @(negedge clk);
    if (chk_lat) begin
      chk("valid_after_push", rx_valid, 1'b1);
      chk("count_after_push", rx_count, 3'd1);
      chk("data_after_push", rx_data, b);
    end
    repeat (5) @(posedge clk);
  endtask

  task automatic drain();
    int n;
    @(posedge clk); #1 rx_ready_man = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(sb_q.size() == 0 && !rx_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1 rx_ready_man = 1'b0;
    chk("drain_done", (sb_q.size() == 0 && !rx_valid), 1'b1);
    chk("drain_count", rx_count, 3'd0);
    chk("rx_data_hold", rx_data, last_pop);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"},   rx_valid, 1'b0);
    chk({tag, "_count"},   rx_count, 3'd0);
    chk({tag, "_data"},    rx_data, 8'h00);
    chk({tag, "_overrun"}, overrun_err, 1'b0);
    chk({tag, "_frame"},   frame_err, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("por");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Single byte latency and content.
    send_byte(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);
    drain();

    // Overrun: fifth byte dropped, first four kept in order.
    pulse_clr();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, (i <= FD), 1'b0, 1'b0);
    @(negedge clk);
    chk("ovr_count", rx_count, 3'd4);
    chk("ovr_flag", overrun_err, 1'b1);
    drain();

    // Push and pop in the same cycle while full.
    pulse_clr();
    @(negedge clk);
    chk("ovr_cleared", overrun_err, 1'b0);
    for (int i = 0; i < FD; i++) send_byte(8'h11 + 8'(i), 1'b1, 1'b1, 1'b0, 1'b0);
    send_byte(8'h77, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("simul_count", rx_count, 3'd4);
    chk("simul_no_ovr", overrun_err, 1'b0);
    drain();

    // Framing error followed by a held break.
    send_byte(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("frm_flag", frame_err, 1'b1);
    chk("frm_count", rx_count, 3'd0);
    #1 rxd = 1'b1;
    rx_ready_man = 1'b1;
    repeat (200) @(posedge clk);
    #1 rx_ready_man = 1'b0;
    chk("break_no_push", rx_count, 3'd0);
    send_byte(8'h5E, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();

    // Short glitch on an idle line.
    pulse_clr();
    @(posedge clk); #1 rxd = 1'b0;
    repeat (6) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("glitch_count", rx_count, 3'd0);
    chk("glitch_frame", frame_err, 1'b0);
    chk("glitch_ovr", overrun_err, 1'b0);

    // Randomized traffic with random consumer stalls and occasional bad stop bits.
    exp_frame = 1'b0;
    rand_en = 1'b1;
    for (int f = 0; f < 30; f++) begin
      logic [7:0] b;
      bit ok;
      b  = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      send_byte(b, ok, ok, 1'b0, 1'b0);
      if (!ok) exp_frame = 1'b1;
      #1 rxd = 1'b1;
      repeat ($urandom_range(0, 20)) @(posedge clk);
    end
    #1 rand_en = 1'b0;
    drain();
    chk("rand_frame", frame_err, exp_frame);
    chk("rand_ovr", overrun_err, 1'b0);

    // Reset mid-frame discards stored and partial bytes.
    send_byte(8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_count", rx_count, 3'd1);
    @(posedge clk); #1 rxd = 1'b0;
    repeat (BD) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (40) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    send_byte(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    chk("post_rst_frame", frame_err, 1'b0);
    chk("post_rst_ovr", overrun_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
